// File: rtl/pp_mult_pkg.sv
// Shared types and elaboration helpers for the partial-product sequential multiplier.
package pp_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned t;
      r = 0;
      t = 1;
      while (t < v) begin
         t = t << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Legal geometry: WIDTH 2..32, ROWS in {1,2,4}, WIDTH a multiple of ROWS.
   function automatic bit rows_legal(input int unsigned width, input int unsigned rows);
      return (width >= 2) && (width <= 32) &&
             ((rows == 1) || (rows == 2) || (rows == 4)) &&
             ((width % rows) == 0);
   endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Gated partial-product row generator: ROWS shifted (x AND y[r]) rows and their sum.
module pp_row_gen
   import pp_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ROWS  = 1,
   parameter int unsigned CNT_W = 4
) (
   input  logic [WIDTH-1:0]   i_x,
   input  logic [ROWS-1:0]    i_ybits,
   input  logic [CNT_W-1:0]   i_cnt,
   output logic [2*WIDTH-1:0] o_sum
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [WIDTH-1:0] w_op [ROWS];

   // A row with a clear multiplier bit presents a constant zero operand to the adder.
   always_comb begin
      o_sum = '0;
      for (int r = 0; r < ROWS; r++) begin
         w_op[r] = i_ybits[r] ? i_x : '0;
         o_sum   = o_sum + (PW'(w_op[r]) << (int'(i_cnt) * int'(ROWS) + r));
      end
   end

endmodule

// File: rtl/pp_seq_mult.sv
// Iterative unsigned multiplier with zero bypass, row gating and early termination.
module pp_seq_mult
   import pp_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ROWS  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned ITER  = WIDTH / ROWS;
   localparam int unsigned CNT_W = clog2(ITER + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   if (!rows_legal(WIDTH, ROWS)) begin : g_bad_geometry
      $fatal(1, "pp_seq_mult: illegal WIDTH/ROWS combination");
   end

   state_t            r_state;
   state_t            w_state_nx;
   logic [WIDTH-1:0]  r_xr;
   logic [WIDTH-1:0]  r_yr;
   logic [PW-1:0]     r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_busy;
   logic [PW-1:0]     r_product;

   logic              w_accept;
   logic              w_zero;
   logic              w_last;
   logic [WIDTH-1:0]  w_yr_shift;
   logic [PW-1:0]     w_rows_sum;
   logic [PW-1:0]     w_acc_nx;
   logic              w_in_ready_nx;
   logic              w_out_valid_nx;
   logic              w_busy_nx;

   assign w_accept   = in_valid & r_in_ready & (r_state == IDLE);
   assign w_zero     = (x == '0) || (y == '0);
   assign w_yr_shift = r_yr >> ROWS;
   assign w_last     = (w_yr_shift == '0) || (r_cnt == CNT_W'(ITER - 1));
   assign w_acc_nx   = r_acc + w_rows_sum;

   pp_row_gen #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .CNT_W (CNT_W)
   ) u_row_gen (
      .i_x     (r_xr),
      .i_ybits (r_yr[ROWS-1:0]),
      .i_cnt   (r_cnt),
      .o_sum   (w_rows_sum)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nx = w_zero ? DONE : BUSY;
         BUSY:    if (w_last) w_state_nx = DONE;
         DONE:    if (out_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Output decode from next state; registered below so flags line up with the state.
   always_comb begin
      w_in_ready_nx  = 1'b0;
      w_out_valid_nx = 1'b0;
      w_busy_nx      = 1'b0;
      case (w_state_nx)
         IDLE:    w_in_ready_nx  = 1'b1;
         BUSY:    w_busy_nx      = 1'b1;
         DONE:    w_out_valid_nx = 1'b1;
         default: w_in_ready_nx  = 1'b0;
      endcase
   end

   // Datapath and registered flags; operands only sampled on an accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xr        <= '0;
         r_yr        <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
      end else begin
         r_in_ready  <= w_in_ready_nx;
         r_out_valid <= w_out_valid_nx;
         r_busy      <= w_busy_nx;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_xr  <= x;
                  r_yr  <= y;
                  r_acc <= '0;
                  r_cnt <= '0;
                  if (w_zero) r_product <= '0;
               end
            end
            BUSY: begin
               r_acc <= w_acc_nx;
               r_yr  <= w_yr_shift;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) r_product <= w_acc_nx;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign product   = r_product;

endmodule

// File: tb/tb_pp_seq_mult.sv
// Scoreboard bench for pp_seq_mult: ROWS=1 and ROWS=4 instances at WIDTH=8.
module tb_pp_seq_mult;

   localparam int W  = 8;
   localparam int NV = 9;

   typedef struct {
      logic [2*W-1:0] p;
      int             k;
      int             e0;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid  [2];
   logic           in_ready  [2];
   logic           out_valid [2];
   logic           out_ready [2];
   logic           busy      [2];
   logic [W-1:0]   x         [2];
   logic [W-1:0]   y         [2];
   logic [2*W-1:0] product   [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Directed vectors: x, y, product, iterations for ROWS=1, iterations for ROWS=4.
   int dx  [NV] = '{255, 200,  0,   165, 1, 77,  13, 255,   128};
   int dy  [NV] = '{255,   3, 77,   150, 1,  0,  16,   1,   128};
   int dp  [NV] = '{65025, 600, 0, 24750, 1,  0, 208, 255, 16384};
   int dk1 [NV] = '{8, 2, 0, 8, 1, 0, 5, 1, 8};
   int dk4 [NV] = '{2, 1, 0, 2, 1, 0, 2, 1, 2};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pp_seq_mult #(.WIDTH(W), .ROWS(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .x(x[0]), .y(y[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .product(product[0]), .busy(busy[0]));

   pp_seq_mult #(.WIDTH(W), .ROWS(4)) u_r4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .x(x[1]), .y(y[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .product(product[1]), .busy(busy[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int kcalc(input logic [W-1:0] a, input logic [W-1:0] b, input int rows);
      int msb = -1;
      if (a == '0 || b == '0) return 0;
      for (int i = 0; i < W; i++) if (b[i]) msb = i;
      return (msb + rows) / rows;
   endfunction

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p, input int k);
      int   t = 0;
      exp_t e;
      @(negedge clk);
      in_valid[i] = 1'b1;
      x[i] = a;
      y[i] = b;
      while (!in_ready[i] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[i]) begin
         chk($sformatf("accept_timeout[%0d]", i), 0, 1);
      end else begin
         e.p  = p;
         e.k  = k;
         e.e0 = cyc + 1;
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      x[i] = '0;
      y[i] = '0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || out_valid[0] || out_valid[1]) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 32'(t < 200), 1);
   endtask

   task automatic rand_run(input int i, input int rows);
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int n = 0; n < 40; n++) begin
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = '0;
         issue(i, a, b, (2*W)'(a) * (2*W)'(b), kcalc(a, b, rows));
      end
   endtask

   // Monitor: pops at each out_valid rise; checks product, latency, busy cycles and hold.
   logic           prev_ov [2];
   logic           prev_or [2];
   logic [2*W-1:0] prev_p  [2];
   int             bcnt    [2];
   exp_t           m_e;
   bit             m_got;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            prev_ov[i] = 1'b0;
            prev_or[i] = 1'b0;
            prev_p[i]  = '0;
            bcnt[i]    = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (busy[i]) bcnt[i]++;
            if (prev_ov[i] && !prev_or[i]) begin
               chk($sformatf("held_valid[%0d]", i), 32'(out_valid[i]), 1);
               chk($sformatf("held_product[%0d]", i), 32'(product[i]), 32'(prev_p[i]));
               chk($sformatf("held_in_ready[%0d]", i), 32'(in_ready[i]), 0);
            end
            if (out_valid[i] && !prev_ov[i]) begin
               m_got = 1'b0;
               if (i == 0 && q0.size() > 0) begin m_e = q0.pop_front(); m_got = 1'b1; end
               if (i == 1 && q1.size() > 0) begin m_e = q1.pop_front(); m_got = 1'b1; end
               if (!m_got) begin
                  chk($sformatf("unexpected_output[%0d]", i), 1, 0);
               end else begin
                  chk($sformatf("product[%0d]", i), 32'(product[i]), 32'(m_e.p));
                  chk($sformatf("latency[%0d]", i), 32'(cyc - m_e.e0), 32'(m_e.k));
                  chk($sformatf("busy_cycles[%0d]", i), 32'(bcnt[i]), 32'(m_e.k));
               end
               bcnt[i] = 0;
            end
            prev_ov[i] = out_valid[i];
            prev_or[i] = out_ready[i];
            prev_p[i]  = product[i];
         end
      end
   end

   task automatic reset_checks(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_in_ready[%0d]", tag, i), 32'(in_ready[i]), 0);
         chk($sformatf("%s_out_valid[%0d]", tag, i), 32'(out_valid[i]), 0);
         chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 0);
         chk($sformatf("%s_product[%0d]", tag, i), 32'(product[i]), 0);
      end
   endtask

   task automatic release_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk($sformatf("%s_ready_before_edge", tag), 32'(in_ready[0]), 0);
      @(posedge clk);
      #1;
      chk($sformatf("%s_ready_after_edge[0]", tag), 32'(in_ready[0]), 1);
      chk($sformatf("%s_ready_after_edge[1]", tag), 32'(in_ready[1]), 1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         x[i] = '0;
         y[i] = '0;
      end
      #1;
      reset_checks("reset");
      repeat (3) @(posedge clk);
      release_reset("init");

      fork
         for (int n = 0; n < NV; n++) issue(0, W'(dx[n]), W'(dy[n]), (2*W)'(dp[n]), dk1[n]);
         for (int n = 0; n < NV; n++) issue(1, W'(dx[n]), W'(dy[n]), (2*W)'(dp[n]), dk4[n]);
      join
      drain();

      // Backpressure: product held in DONE while a second operand pair waits upstream.
      @(posedge clk);
      #1 out_ready[0] = 1'b0;
      issue(0, 8'd200, 8'd3, 16'd600, 2);
      repeat (6) @(posedge clk);
      fork
         begin
            repeat (5) @(posedge clk);
            #1 out_ready[0] = 1'b1;
         end
         issue(0, 8'd165, 8'd150, 16'd24750, 8);
      join
      drain();

      fork
         rand_run(0, 1);
         rand_run(1, 4);
      join
      drain();

      // Reset mid-operation: in-flight product is discarded.
      issue(0, 8'd255, 8'd128, 16'd32640, 8);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      reset_checks("midreset");
      q0.delete();
      q1.delete();
      repeat (3) @(posedge clk);
      release_reset("midrel");
      repeat (15) @(negedge clk);
      chk("no_output_after_reset", 32'(out_valid[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
